// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//
// Hardwired Moore sequencer for the single-bus 32-bit datapath.  It holds the
// instruction register and steps through fetch (T0-T2) and execute (T3-T7)
// states.  Every datapath strobe is a combinational decode of the registered
// state and IR.  T1 (instruction read), LD T6 (operand read) and ST T7
// (operand write) wait for mem_ready.
//
// Ports
//   clock, clear          rising-edge clock, synchronous active-low reset
//   bus_in[31:0]          BusMuxOut, captured into IR at the end of T2
//   mem_ready             memory finishes the current Read/Write this cycle
//   start                 leaves the HALT state
//   reg_out/reg_in[15:0]  one-hot R0..R15 bus-out select / load enable
//   HIout..Cout           bus source selects
//   HIin..OutPortin       register load enables
//   BAout, Read, Write    R0-reads-zero, memory read, memory write
//   IncPC                 ALU increments its bus operand
//   op[4:0]               ALU operation
//   c_sext[31:0]          IR[18:0] sign-extended (bus source when Cout=1)
//   run, illegal          not-halted flag, one-cycle illegal-opcode pulse
// ---------------------------------------------------------------------------
module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] bus_in,
    input  logic        mem_ready,
    input  logic        start,
    output logic [15:0] reg_out,
    output logic [15:0] reg_in,
    output logic        HIout,
    output logic        LOout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        PCout,
    output logic        MDRout,
    output logic        InPortout,
    output logic        Cout,
    output logic        HIin,
    output logic        LOin,
    output logic        Zhighin,
    output logic        Zlowin,
    output logic        PCin,
    output logic        MDRin,
    output logic        MARin,
    output logic        IRin,
    output logic        Yin,
    output logic        OutPortin,
    output logic        BAout,
    output logic        Read,
    output logic        Write,
    output logic        IncPC,
    output logic [4:0]  op,
    output logic [31:0] c_sext,
    output logic        run,
    output logic        illegal
);

    typedef enum logic [3:0] {
        stReset, stT0, stT1, stT2, stT3, stT4, stT5, stT6, stT7, stHalt
    } state_t;

    typedef enum logic [3:0] {
        clsAlu3, clsAluImm, clsMulDiv, clsUnary, clsLoad, clsLoadImm,
        clsStore, clsIn, clsOut, clsMfhi, clsMflo, clsNop, clsHalt, clsIllegal
    } opClass_t;

    state_t      state;
    state_t      nextState;
    logic [31:0] ir;
    opClass_t    irClass;
    opClass_t    fetchClass;
    logic [15:0] raHot;
    logic [15:0] rbHot;
    logic [15:0] rcHot;

    // Groups the 5-bit opcode into the instruction families that share a
    // step sequence.  Opcodes without an assigned meaning (10011-10101 and
    // 11100-11111) are all treated as illegal.
    function automatic opClass_t classify(input logic [4:0] opc);
        opClass_t cls;
        if (opc == 5'd0)                        cls = clsLoad;
        else if (opc == 5'd1)                   cls = clsLoadImm;
        else if (opc == 5'd2)                   cls = clsStore;
        else if (opc <= 5'd11)                  cls = clsAlu3;
        else if (opc <= 5'd14)                  cls = clsAluImm;
        else if (opc <= 5'd16)                  cls = clsMulDiv;
        else if (opc <= 5'd18)                  cls = clsUnary;
        else if (opc == 5'd22)                  cls = clsIn;
        else if (opc == 5'd23)                  cls = clsOut;
        else if (opc == 5'd24)                  cls = clsMfhi;
        else if (opc == 5'd25)                  cls = clsMflo;
        else if (opc == 5'd26)                  cls = clsNop;
        else if (opc == 5'd27)                  cls = clsHalt;
        else                                    cls = clsIllegal;
        return cls;
    endfunction

    // The T2 branch has to look at the word on the bus because IR only
    // takes it at the end of T2; everything later decodes the stable IR.
    assign irClass    = classify(ir[31:27]);
    assign fetchClass = classify(bus_in[31:27]);
    assign raHot      = 16'h0001 << ir[26:23];
    assign rbHot      = 16'h0001 << ir[22:19];
    assign rcHot      = 16'h0001 << ir[18:15];
    assign c_sext     = {{13{ir[18]}}, ir[18:0]};

    // State and instruction register.  Reset wins over everything, including
    // a pending IR load, so a reset during T2 leaves IR cleared.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state <= stReset;
            ir    <= '0;
        end else begin
            state <= nextState;
            if (state == stT2) begin
                ir <= bus_in;
            end
        end
    end

    // Next-state logic.  Each family leaves for T0 from its last step; the
    // three memory stall states hold until mem_ready is seen.
    always_comb begin
        nextState = stReset;
        case (state)
            stReset: nextState = stT0;
            stT0:    nextState = stT1;
            stT1:    nextState = mem_ready ? stT2 : stT1;
            stT2: begin
                if (fetchClass == clsNop)       nextState = stT0;
                else if (fetchClass == clsHalt) nextState = stHalt;
                else                            nextState = stT3;
            end
            stT3: begin
                case (irClass)
                    clsAlu3, clsAluImm, clsMulDiv, clsUnary,
                    clsLoad, clsLoadImm, clsStore: nextState = stT4;
                    default:                       nextState = stT0;
                endcase
            end
            stT4:    nextState = (irClass == clsUnary) ? stT0 : stT5;
            stT5: begin
                case (irClass)
                    clsMulDiv, clsLoad, clsStore: nextState = stT6;
                    default:                      nextState = stT0;
                endcase
            end
            stT6: begin
                if (irClass == clsLoad)       nextState = mem_ready ? stT7 : stT6;
                else if (irClass == clsStore) nextState = stT7;
                else                          nextState = stT0;
            end
            stT7: begin
                if (irClass == clsStore) nextState = mem_ready ? stT0 : stT7;
                else                     nextState = stT0;
            end
            stHalt:  nextState = start ? stT0 : stHalt;
            default: nextState = stReset;
        endcase
    end

    // Moore output decode.  Everything defaults to 0 so each state only names
    // the strobes it raises; RESET and HALT therefore drive nothing.
    always_comb begin
        reg_out   = '0;
        reg_in    = '0;
        HIout     = 1'b0;
        LOout     = 1'b0;
        Zhighout  = 1'b0;
        Zlowout   = 1'b0;
        PCout     = 1'b0;
        MDRout    = 1'b0;
        InPortout = 1'b0;
        Cout      = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        Zhighin   = 1'b0;
        Zlowin    = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        MARin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        OutPortin = 1'b0;
        BAout     = 1'b0;
        Read      = 1'b0;
        Write     = 1'b0;
        IncPC     = 1'b0;
        op        = '0;
        illegal   = 1'b0;
        run       = (state != stReset) && (state != stHalt);
        case (state)
            stT0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; op = 5'b00011;
                Zhighin = 1'b1; Zlowin = 1'b1;
            end
            stT1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            stT2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            stT3: begin
                case (irClass)
                    clsAlu3, clsAluImm: begin reg_out = rbHot; Yin = 1'b1; end
                    clsMulDiv:          begin reg_out = raHot; Yin = 1'b1; end
                    clsUnary: begin
                        reg_out = rbHot; op = ir[31:27]; Zhighin = 1'b1; Zlowin = 1'b1;
                    end
                    clsLoad, clsLoadImm, clsStore: begin
                        reg_out = rbHot; BAout = 1'b1; Yin = 1'b1;
                    end
                    clsIn:      begin InPortout = 1'b1; reg_in = raHot; end
                    clsOut:     begin reg_out = raHot; OutPortin = 1'b1; end
                    clsMfhi:    begin HIout = 1'b1; reg_in = raHot; end
                    clsMflo:    begin LOout = 1'b1; reg_in = raHot; end
                    clsIllegal: illegal = 1'b1;
                    default: ;
                endcase
            end
            stT4: begin
                case (irClass)
                    clsAlu3: begin
                        reg_out = rcHot; op = ir[31:27]; Zhighin = 1'b1; Zlowin = 1'b1;
                    end
                    clsAluImm: begin
                        Cout = 1'b1; op = ir[31:27]; Zhighin = 1'b1; Zlowin = 1'b1;
                    end
                    clsMulDiv: begin
                        reg_out = rbHot; op = ir[31:27]; Zhighin = 1'b1; Zlowin = 1'b1;
                    end
                    clsUnary: begin Zlowout = 1'b1; reg_in = raHot; end
                    clsLoad, clsLoadImm, clsStore: begin
                        Cout = 1'b1; op = 5'b00011; Zhighin = 1'b1; Zlowin = 1'b1;
                    end
                    default: ;
                endcase
            end
            stT5: begin
                case (irClass)
                    clsAlu3, clsAluImm, clsLoadImm: begin Zlowout = 1'b1; reg_in = raHot; end
                    clsMulDiv:                      begin Zlowout = 1'b1; LOin = 1'b1; end
                    clsLoad, clsStore:              begin Zlowout = 1'b1; MARin = 1'b1; end
                    default: ;
                endcase
            end
            stT6: begin
                case (irClass)
                    clsMulDiv: begin Zhighout = 1'b1; HIin = 1'b1; end
                    clsLoad:   begin Read = 1'b1; MDRin = 1'b1; end
                    clsStore:  begin reg_out = raHot; MDRin = 1'b1; end
                    default: ;
                endcase
            end
            stT7: begin
                case (irClass)
                    clsLoad:  begin MDRout = 1'b1; reg_in = raHot; end
                    clsStore: Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//
// Scoreboard bench for control_unit.  The stimulus process expands each
// instruction into its list of expected control words (from the instruction
// family tables), drives bus_in/mem_ready/start/clear cycle by cycle and
// pushes the expected word for every cycle into a queue.  A separate monitor
// pops one expectation per cycle and compares it against the sampled outputs.
// ---------------------------------------------------------------------------
module tb_control_unit;

    typedef struct packed {
        logic [15:0] regOut;
        logic [15:0] regIn;
        logic        hiOut, loOut, zHighOut, zLowOut, pcOut, mdrOut, inPortOut, cOut;
        logic        hiIn, loIn, zHighIn, zLowIn, pcIn, mdrIn, marIn, irIn, yIn, outPortIn;
        logic        baOut, read, write, incPc;
        logic [4:0]  op;
        logic [31:0] cSext;
        logic        run, illegal;
    } ctrl_t;

    typedef struct {
        ctrl_t w;
        string tag;
    } exp_t;

    typedef struct {
        ctrl_t w;
        logic  stall;
        string tag;
    } step_t;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] busIn = '0;
    logic        memReady = 1'b0;
    logic        start = 1'b0;
    logic [15:0] regOut, regIn;
    logic        hiOut, loOut, zHighOut, zLowOut, pcOut, mdrOut, inPortOut, cOut;
    logic        hiIn, loIn, zHighIn, zLowIn, pcIn, mdrIn, marIn, irIn, yIn, outPortIn;
    logic        baOut, read, write, incPc;
    logic [4:0]  op;
    logic [31:0] cSext;
    logic        run, illegal;

    int          checks = 0;
    int          passes = 0;
    exp_t        expQ[$];
    step_t       stepQ[$];
    logic [31:0] modelIr = '0;

    control_unit dut (
        .clock(clock), .clear(clear), .bus_in(busIn), .mem_ready(memReady), .start(start),
        .reg_out(regOut), .reg_in(regIn),
        .HIout(hiOut), .LOout(loOut), .Zhighout(zHighOut), .Zlowout(zLowOut),
        .PCout(pcOut), .MDRout(mdrOut), .InPortout(inPortOut), .Cout(cOut),
        .HIin(hiIn), .LOin(loIn), .Zhighin(zHighIn), .Zlowin(zLowIn), .PCin(pcIn),
        .MDRin(mdrIn), .MARin(marIn), .IRin(irIn), .Yin(yIn), .OutPortin(outPortIn),
        .BAout(baOut), .Read(read), .Write(write), .IncPC(incPc),
        .op(op), .c_sext(cSext), .run(run), .illegal(illegal)
    );

    // Free-running 10 ns clock.
    always #5 clock = ~clock;

    // Gathers the DUT outputs into the same layout as the expected words.
    function automatic ctrl_t sampleDut();
        ctrl_t a;
        a.regOut = regOut;   a.regIn = regIn;
        a.hiOut = hiOut;     a.loOut = loOut;     a.zHighOut = zHighOut; a.zLowOut = zLowOut;
        a.pcOut = pcOut;     a.mdrOut = mdrOut;   a.inPortOut = inPortOut; a.cOut = cOut;
        a.hiIn = hiIn;       a.loIn = loIn;       a.zHighIn = zHighIn;   a.zLowIn = zLowIn;
        a.pcIn = pcIn;       a.mdrIn = mdrIn;     a.marIn = marIn;       a.irIn = irIn;
        a.yIn = yIn;         a.outPortIn = outPortIn;
        a.baOut = baOut;     a.read = read;       a.write = write;       a.incPc = incPc;
        a.op = op;           a.cSext = cSext;     a.run = run;           a.illegal = illegal;
        return a;
    endfunction

    function automatic logic [31:0] sext19(input logic [31:0] v);
        return {{13{v[18]}}, v[18:0]};
    endfunction

    // A running-state word with no strobes raised.
    function automatic ctrl_t base();
        ctrl_t w;
        w = '0;
        w.run = 1'b1;
        return w;
    endfunction

    task automatic checkOutput(input exp_t e, input ctrl_t a);
        checks++;
        if (a === e.w) passes++;
        else $display("[TB] FAIL %s got=%h want=%h", e.tag, a, e.w);
    endtask

    // One clock cycle: record what the outputs must be during this cycle and
    // set the inputs that the next rising edge will see.
    task automatic applyStimulus(input ctrl_t w, input string tag, input logic mr,
                                 input logic [31:0] bus, input logic clr, input logic st);
        exp_t e;
        @(posedge clock);
        #1;
        e.w = w;
        e.tag = tag;
        expQ.push_back(e);
        memReady = mr;
        busIn    = bus;
        clear    = clr;
        start    = st;
    endtask

    // Holds the DUT in reset for n cycles, releasing clear on the last one.
    task automatic resetDut(input int n);
        modelIr = '0;
        for (int i = 0; i < n; i++) begin
            applyStimulus('0, "reset", 1'($urandom % 2), $urandom,
                          (i < n - 1) ? 1'b0 : 1'b1, 1'($urandom % 2));
        end
    endtask

    task automatic addStep(input ctrl_t w, input logic stall, input string tag);
        step_t s;
        s.w = w;
        s.stall = stall;
        s.tag = tag;
        stepQ.push_back(s);
    endtask

    // Reference model: the step list each instruction family walks through.
    task automatic buildSteps(input logic [31:0] instr);
        int          opc;
        logic [15:0] ra, rb, rc;
        ctrl_t       w;
        opc = int'(instr[31:27]);
        ra  = 16'h0001 << instr[26:23];
        rb  = 16'h0001 << instr[22:19];
        rc  = 16'h0001 << instr[18:15];
        stepQ.delete();
        w = base(); w.pcOut = 1; w.marIn = 1; w.incPc = 1; w.op = 5'd3;
        w.zHighIn = 1; w.zLowIn = 1;                        addStep(w, 0, "T0");
        w = base(); w.zLowOut = 1; w.pcIn = 1; w.read = 1; w.mdrIn = 1;
        addStep(w, 1, "T1");
        w = base(); w.mdrOut = 1; w.irIn = 1;               addStep(w, 0, "T2");
        if (opc >= 3 && opc <= 14) begin
            w = base(); w.regOut = rb; w.yIn = 1;           addStep(w, 0, "T3");
            w = base();
            if (opc <= 11) w.regOut = rc;
            else           w.cOut = 1;
            w.op = instr[31:27]; w.zHighIn = 1; w.zLowIn = 1; addStep(w, 0, "T4");
            w = base(); w.zLowOut = 1; w.regIn = ra;        addStep(w, 0, "T5");
        end else if (opc == 15 || opc == 16) begin
            w = base(); w.regOut = ra; w.yIn = 1;           addStep(w, 0, "T3");
            w = base(); w.regOut = rb; w.op = instr[31:27];
            w.zHighIn = 1; w.zLowIn = 1;                    addStep(w, 0, "T4");
            w = base(); w.zLowOut = 1; w.loIn = 1;          addStep(w, 0, "T5");
            w = base(); w.zHighOut = 1; w.hiIn = 1;         addStep(w, 0, "T6");
        end else if (opc == 17 || opc == 18) begin
            w = base(); w.regOut = rb; w.op = instr[31:27];
            w.zHighIn = 1; w.zLowIn = 1;                    addStep(w, 0, "T3");
            w = base(); w.zLowOut = 1; w.regIn = ra;        addStep(w, 0, "T4");
        end else if (opc <= 2) begin
            w = base(); w.regOut = rb; w.baOut = 1; w.yIn = 1; addStep(w, 0, "T3");
            w = base(); w.cOut = 1; w.op = 5'd3; w.zHighIn = 1; w.zLowIn = 1;
            addStep(w, 0, "T4");
            if (opc == 1) begin
                w = base(); w.zLowOut = 1; w.regIn = ra;    addStep(w, 0, "T5");
            end else begin
                w = base(); w.zLowOut = 1; w.marIn = 1;     addStep(w, 0, "T5");
                if (opc == 0) begin
                    w = base(); w.read = 1; w.mdrIn = 1;    addStep(w, 1, "T6");
                    w = base(); w.mdrOut = 1; w.regIn = ra; addStep(w, 0, "T7");
                end else begin
                    w = base(); w.regOut = ra; w.mdrIn = 1; addStep(w, 0, "T6");
                    w = base(); w.write = 1;                addStep(w, 1, "T7");
                end
            end
        end else if (opc == 22) begin
            w = base(); w.inPortOut = 1; w.regIn = ra;      addStep(w, 0, "T3");
        end else if (opc == 23) begin
            w = base(); w.regOut = ra; w.outPortIn = 1;     addStep(w, 0, "T3");
        end else if (opc == 24) begin
            w = base(); w.hiOut = 1; w.regIn = ra;          addStep(w, 0, "T3");
        end else if (opc == 25) begin
            w = base(); w.loOut = 1; w.regIn = ra;          addStep(w, 0, "T3");
        end else if (opc >= 28) begin
            w = base(); w.illegal = 1;                      addStep(w, 0, "T3");
        end
    endtask

    // Runs one instruction through the DUT.  Stall steps last waits+1 cycles
    // with mem_ready raised only in the final one.  abortAt (cycle index
    // within the instruction, -1 for none) drops clear for two cycles there.
    task automatic runInstr(input logic [31:0] instr, input int fetchWaits,
                            input int memWaits, input int haltLen, input int abortAt);
        int    cyc;
        ctrl_t w;
        string tag;
        logic  mr;
        cyc = 0;
        buildSteps(instr);
        for (int s = 0; s < stepQ.size(); s++) begin
            int reps;
            reps = stepQ[s].stall ? (((s == 1) ? fetchWaits : memWaits) + 1) : 1;
            for (int k = 0; k < reps; k++) begin
                w = stepQ[s].w;
                w.cSext = sext19(modelIr);
                tag = $sformatf("ins=%h %s.%0d", instr, stepQ[s].tag, k);
                mr = stepQ[s].stall ? ((k == reps - 1) ? 1'b1 : 1'b0) : 1'($urandom % 2);
                applyStimulus(w, tag, mr, (s == 2) ? instr : $urandom,
                              (cyc == abortAt) ? 1'b0 : 1'b1, 1'($urandom % 2));
                if (cyc == abortAt) begin
                    resetDut(2);
                    return;
                end
                cyc++;
            end
            if (s == 2) modelIr = instr;
        end
        if (instr[31:27] == 5'd27) begin
            for (int h = 0; h < haltLen; h++) begin
                w = '0;
                w.cSext = sext19(modelIr);
                applyStimulus(w, $sformatf("ins=%h HALT.%0d", instr, h), 1'($urandom % 2),
                              $urandom, (cyc == abortAt) ? 1'b0 : 1'b1,
                              (h == haltLen - 1) ? 1'b1 : 1'b0);
                if (cyc == abortAt) begin
                    resetDut(2);
                    return;
                end
                cyc++;
            end
        end
    endtask

    // Monitor: one expected word per cycle, compared mid-cycle on the
    // falling edge where the Moore outputs are settled.
    initial begin
        forever begin
            @(negedge clock);
            if (expQ.size() > 0) begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput(e, sampleDut());
            end
        end
    end

    // Safety net so a stuck run still ends with a report.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired got=running want=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios first, then randomized instruction streams.
    initial begin
        logic [31:0] instr;
        int          opc;
        resetDut(2);
        runInstr(32'h1A200000, 3, 0, 0, -1);
        runInstr(32'h19A28000, 0, 0, 0, -1);
        runInstr(32'h0087FFFF, 0, 2, 0, -1);
        runInstr(32'h7B380000, 1, 0, 0, -1);
        runInstr(32'hD8000000, 0, 0, 5, -1);
        runInstr(32'hD8000000, 0, 0, 1, -1);
        runInstr(32'hF0000000, 0, 0, 0, -1);
        runInstr(32'h0087FFFF, 0, 3, 0, 7);
        runInstr(32'h14900010, 1, 2, 0, -1);
        runInstr(32'hD0000000, 0, 0, 0, -1);
        runInstr(32'hB1000000, 0, 0, 0, -1);
        for (int n = 0; n < 120; n++) begin
            opc = int'($urandom_range(0, 28));
            if (opc >= 19) opc += 3;
            instr = $urandom;
            instr[31:27] = 5'(opc);
            runInstr(instr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(1, 4)),
                     ($urandom % 8 == 0) ? int'($urandom_range(0, 9)) : -1);
        end
        @(negedge clock);
        #1;
        checks++;
        if (expQ.size() == 0) passes++;
        else $display("[TB] FAIL drain got=%0d want=0 pending expectations", expQ.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Moore sequencer for the single-bus 32-bit datapath (R0–R15, HI/LO, Y, Z, PC, MDR, in/out ports, ALU). It holds the instruction register and steps fetch/decode/execute states. In each state it drives every bus-out select, register-enable, ALU op and memory strobe the datapath needs. It stalls on a memory-ready handshake and supports halt and restart.

## Interface
- No parameters; opcode map fixed below.
- clock  in  1  rising-edge clock
- clear  in  1  synchronous, active-low reset
- bus_in  in  32  datapath BusMuxOut, captured into IR on IRin
- mem_ready  in  1  memory completes the current Read/Write this cycle
- start  in  1  leaves HALT state
- reg_out, reg_in  out  16 each  one-hot R0..R15 bus-out select / load enable
- HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout  out  1 each  bus source selects
- HIin, LOin, Zhighin, Zlowin, PCin, MDRin, MARin, IRin, Yin, OutPortin  out  1 each  load enables
- BAout, Read, Write, IncPC  out  1 each  R0-reads-zero, memory read, memory write, ALU increment
- op  out  5  ALU operation
- c_sext  out  32  IR[18:0] sign-extended (bus source when Cout=1)
- run, illegal  out  1 each  not-halted flag; one-cycle illegal-opcode pulse

## Operation
- IR fields: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15], C IR[18:0].
- "Zin" means Zhighin=Zlowin=1. All unlisted outputs are 0 in each state.
- Fetch:
  - T0: PCout, MARin, IncPC, op=00011, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Stall until mem_ready.
  - T2: MDRout, IRin.
- Execute by opcode:
  - ALU3, opcodes 00011–01011 (add, sub, and, or, ror, rol, shr, shra, shl): T3 Rb out, Yin; T4 Rc out, op=opcode, Zin; T5 Zlowout, Ra in.
  - ALUI, opcodes 01100–01110 (addi, andi, ori): T3 Rb out, Yin; T4 Cout, op=opcode, Zin; T5 Zlowout, Ra in.
  - MULDIV, opcodes 01111 and 10000: T3 Ra out, Yin; T4 Rb out, op, Zin; T5 Zlowout, LOin; T6 Zhighout, HIin.
  - UNARY, opcodes 10001 and 10010 (neg, not): T3 Rb out, op, Zin; T4 Zlowout, Ra in.
  - LD 00000 / LDI 00001:
    - T3 Rb out, BAout, Yin; T4 Cout, op=00011, Zin.
    - LDI: T5 Zlowout, Ra in.
    - LD: T5 Zlowout, MARin; T6 Read, MDRin, stall until mem_ready; T7 MDRout, Ra in.
  - ST 00010: T3–T5 as LD; T6 Ra out, MDRin (Read=0); T7 Write, stall until mem_ready.
  - IN 10110: T3 InPortout, Ra in. OUT 10111: T3 Ra out, OutPortin.
  - MFHI 11000: T3 HIout, Ra in. MFLO 11001: T3 LOout, Ra in.
  - NOP 11010: T2 goes straight to T0.
  - HALT 11011: enter HALT, run=0, all strobes 0. The cycle after start=1 is T0.
  - Opcodes 11100–11111: pulse illegal in T3, then T0.
- The last state of every instruction goes to T0.
- reg_out/reg_in are one-hot decodes of the named field. Never more than one bit is set.

## Timing
- clear=0 at a rising edge puts the state in RESET: all outputs 0, IR=0, run=0, no stall. This holds mid-instruction and mid-stall.
- The first edge with clear=1 moves RESET to T0, so T0 is asserted one cycle after clear releases.
- Outputs are a combinational decode of registered state and IR; no output depends on mem_ready.
- Stall states hold their outputs unchanged and advance on the edge where mem_ready=1.
  - mem_ready=1 on the first cycle means zero added wait cycles.
  - mem_ready outside a stall state is ignored.
- IR loads only at the T2 edge. IR is stable through execute.
- Cycle counts with no waits: NOP 3; IN/OUT/MFHI/MFLO 4; UNARY 5; ALU3, ALUI and LDI 6; MULDIV 7; LD and ST 8.
- start while not in HALT is ignored. HALT with start=1 in its first cycle still spends exactly one cycle in HALT.

## Test plan
- Reset: clear=0 for 2 cycles mid-LD T6 -> outputs all 0, run=0. After release: T0 pattern (PCout, MARin, IncPC, op=00011, Zhighin, Zlowin) on the next cycle.
- Fetch stall: mem_ready low 3 cycles in T1 -> Read/MDRin/PCin held 4 cycles; IRin exactly once; IR=bus_in value 0x1A200000.
- ALU3 add R3,R4,R5 (0x19A28000) -> T3 reg_out=0x0010, Yin; T4 reg_out=0x0020, op=00011, Zin; T5 Zlowout, reg_in=0x0008.
- LD R1,0x7FFFF(R0) with 2-cycle memory wait -> c_sext=0xFFFFFFFF, BAout in T3, Read held 3 cycles in T6, reg_in=0x0002 in T7; total 10 cycles.
- MUL R6,R7 -> LOin in T5, HIin in T6; HALT then start=1 after 5 cycles -> run low 5 cycles, T0 next.
- Opcode 11110 -> illegal=1 for one cycle, no reg_in/Write asserted, next fetch begins.
